// File: rtl/fetch_stage_if.sv
// Fetch-stage signal bundle: control inputs, instruction-memory port and IF/ID outputs.
// The bench drives through "master"; the fetch stage uses "slave".
interface fetch_stage_if;
  logic        start;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        busy;
  logic        halted;

  modport master (
    output start, stall, branch_taken, branch_target, imem_data,
    input  imem_addr, if_id_instr, if_id_pc4, if_id_valid, busy, halted
  );

  modport slave (
    input  start, stall, branch_taken, branch_target, imem_data,
    output imem_addr, if_id_instr, if_id_pc4, if_id_valid, busy, halted
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads a combinational instruction ROM and loads IF/ID.
//   state    | meaning
//   S_IDLE   | after reset, waiting for start; PC parked at RESET_PC
//   S_RUN    | fetching one instruction per cycle
//   S_HALTED | halt word seen; PC frozen until a redirect or a new start
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input logic          clk,
  input logic          rst,
  fetch_stage_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] instr, instr_nx;
  logic [31:0] pc4, pc4_nx;
  logic        valid, valid_nx;
  logic [31:0] target;

  assign target = {bus.branch_target[31:2], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
      instr <= 32'h0;
      pc4   <= 32'h0;
      valid <= 1'b0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      instr <= instr_nx;
      pc4   <= pc4_nx;
      valid <= valid_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    instr_nx = instr;
    pc4_nx   = pc4;
    valid_nx = valid;
    case (state)
      S_IDLE: begin
        valid_nx = 1'b0;
        if (bus.start) begin
          state_nx = S_RUN;
          pc_nx    = RESET_PC;
        end
      end
      S_RUN: begin
        // Redirect wins over stall and also squashes a halt word on the wrong path.
        if (bus.branch_taken) begin
          pc_nx    = target;
          valid_nx = 1'b0;
        end else if (bus.stall) begin
          pc_nx = pc;
        end else if (bus.imem_data == HALT_INSTR) begin
          valid_nx = 1'b0;
          state_nx = S_HALTED;
        end else begin
          instr_nx = bus.imem_data;
          pc4_nx   = pc + 32'd4;
          valid_nx = 1'b1;
          pc_nx    = pc + 32'd4;
        end
      end
      S_HALTED: begin
        valid_nx = 1'b0;
        if (bus.branch_taken) begin
          pc_nx    = target;
          state_nx = S_RUN;
        end else if (bus.start) begin
          pc_nx    = RESET_PC;
          state_nx = S_RUN;
        end
      end
      default: begin
        state_nx = S_IDLE;
        pc_nx    = RESET_PC;
        valid_nx = 1'b0;
      end
    endcase
  end

  assign bus.imem_addr   = pc;
  assign bus.if_id_instr = instr;
  assign bus.if_id_pc4   = pc4;
  assign bus.if_id_valid = valid;
  assign bus.busy        = (state == S_RUN);
  assign bus.halted      = (state == S_HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic against a behavioural model.
module tb_fetch_stage;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(32'h0), .HALT_INSTR(HALT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [64];
  assign bus.imem_data = (bus.imem_addr < 32'd256) ? mem[bus.imem_addr[7:2]]
                                                   : (bus.imem_addr ^ 32'h5a5a_0000);

  int vectors = 0;
  int miscompares = 0;

  string       m_mode;
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;

  function automatic logic [31:0] rom(input logic [31:0] a);
    logic [5:0] idx;
    idx = a[7:2];
    return (a < 32'd256) ? mem[idx] : (a ^ 32'h5a5a_0000);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = "idle";
    m_pc    = 32'h0;
    m_instr = 32'h0;
    m_pc4   = 32'h0;
    m_valid = 1'b0;
  endtask

  task automatic check_all();
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("if_id_instr", bus.if_id_instr, m_instr);
    chk("if_id_pc4", bus.if_id_pc4, m_pc4);
    chk("if_id_valid", {31'h0, bus.if_id_valid}, {31'h0, m_valid});
    chk("busy", {31'h0, bus.busy}, {31'h0, m_mode == "run"});
    chk("halted", {31'h0, bus.halted}, {31'h0, m_mode == "halted"});
  endtask

  // One clock: advance the model from the current inputs, then compare after the edge.
  task automatic step();
    logic [31:0] word, tgt;
    word = rom(m_pc);
    tgt  = bus.branch_target & ~32'd3;
    if (m_mode == "idle") begin
      if (bus.start) begin m_mode = "run"; m_pc = 32'h0; end
    end else if (m_mode == "run") begin
      if (bus.branch_taken) begin
        m_pc = tgt; m_valid = 1'b0;
      end else if (bus.stall) begin
        // everything holds
      end else if (word == HALT) begin
        m_valid = 1'b0; m_mode = "halted";
      end else begin
        m_instr = word; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
      end
    end else begin
      m_valid = 1'b0;
      if (bus.branch_taken) begin m_pc = tgt; m_mode = "run"; end
      else if (bus.start) begin m_pc = 32'h0; m_mode = "run"; end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Called just after a step: assert rst between edges and check the immediate effect.
  task automatic mid_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drive(input logic s, input logic st, input logic br, input logic [31:0] t);
    bus.start = s; bus.stall = st; bus.branch_taken = br; bus.branch_target = t;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom & 32'hFFFF_FFFE;
    mem[0]  = 32'h2001_0005;
    mem[1]  = 32'h2002_0003;
    mem[4]  = HALT;
    mem[12] = HALT;
    drive(1'b0, 1'b0, 1'b0, 32'h0);

    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk); #1;
    rst = 1'b0;

    drive(1'b0, 1'b1, 1'b1, 32'h80);
    step(); step();

    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    chk("start_busy", {31'h0, bus.busy}, 32'h1);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("first_instr", bus.if_id_instr, 32'h2001_0005);
    chk("first_pc4", bus.if_id_pc4, 32'h4);
    step();
    chk("second_instr", bus.if_id_instr, 32'h2002_0003);
    chk("second_pc4", bus.if_id_pc4, 32'h8);

    drive(1'b0, 1'b1, 1'b0, 32'h0);
    step();
    chk("stall_addr1", bus.imem_addr, 32'h8);
    step();
    chk("stall_addr2", bus.imem_addr, 32'h8);
    chk("stall_instr", bus.if_id_instr, 32'h2002_0003);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("unstall_pc4", bus.if_id_pc4, 32'hC);

    drive(1'b0, 1'b1, 1'b1, 32'h43);
    step();
    chk("br_addr", bus.imem_addr, 32'h40);
    chk("br_bubble", {31'h0, bus.if_id_valid}, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("br_tgt_pc4", bus.if_id_pc4, 32'h44);

    drive(1'b0, 1'b0, 1'b1, 32'h10);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("halt_flag", {31'h0, bus.halted}, 32'h1);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("halt_addr", bus.imem_addr, 32'h10);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    step();
    chk("restart_addr", bus.imem_addr, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) step();
    chk("rehalt", {31'h0, bus.halted}, 32'h1);
    drive(1'b0, 1'b0, 1'b1, 32'h20);
    step();
    chk("halt_redirect", bus.imem_addr, 32'h20);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) step();
    drive(1'b0, 1'b0, 1'b1, 32'h80);
    step();
    chk("squash_halted", {31'h0, bus.halted}, 32'h0);
    chk("squash_addr", bus.imem_addr, 32'h80);

    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("wrap_pc4", bus.if_id_pc4, 32'h0);
    chk("wrap_addr", bus.imem_addr, 32'h0);
    step();
    mid_reset();
    for (int i = 0; i < 3; i++) step();
    chk("post_rst_busy", {31'h0, bus.busy}, 32'h0);

    for (int i = 0; i < 64; i++)
      mem[i] = ($urandom_range(0, 9) == 0) ? HALT : ($urandom & 32'hFFFF_FFFE);
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
            ($urandom_range(0, 19) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                         : $urandom_range(0, 255));
      step();
      if ($urandom_range(0, 99) == 0) mid_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
